// File: rtl/dmem_vector_reader.sv
// Read-side engine for the word-addressed data RAM: issues 1 or LANES sequential reads
// through a one-cycle-latency port and packs the returned words into one response.
module dmem_vector_reader #(
  parameter int S     = 32,
  parameter int LANES = 6,
  parameter int V     = 192,
  parameter int SIZE  = 30015
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [S-1:0] req_addr,
  input  logic         req_is_vector,
  output logic         mem_re,
  output logic [S-1:0] mem_addr,
  input  logic [S-1:0] mem_rdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [V-1:0] rsp_data,
  output logic         rsp_oob
);

  localparam int IDX_W = $clog2(LANES + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_t;

  state_t             state;
  logic [S-1:0]       base;
  logic [IDX_W-1:0]   n_lanes;
  logic [IDX_W-1:0]   issue_idx;
  logic [IDX_W-1:0]   cap_idx;
  logic               cap_re;

  logic [S-1:0]       issue_base;
  logic [IDX_W-1:0]   next_idx;
  logic [S:0]         next_addr;
  logic               next_in_range;
  logic               last_issued;

  // Address of the lane about to be issued; the extra bit keeps base+i from wrapping
  // into the valid range when base sits near the top of the address space.
  always_comb begin
    issue_base    = (state == IDLE) ? req_addr : base;
    next_idx      = (state == IDLE) ? '0 : issue_idx + IDX_W'(1);
    next_addr     = {1'b0, issue_base} + {{(S + 1 - IDX_W){1'b0}}, next_idx};
    next_in_range = next_addr < (S + 1)'(SIZE);
    last_issued   = (issue_idx + IDX_W'(1)) >= n_lanes;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      n_lanes   <= '0;
      issue_idx <= '0;
      cap_idx   <= '0;
      cap_re    <= 1'b0;
      req_ready <= 1'b1;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_oob   <= 1'b0;
    end else begin
      // Read data arrives one cycle after its mem_re, so capture follows a delayed copy.
      cap_re  <= mem_re;
      cap_idx <= issue_idx;
      if (cap_re && (cap_idx < n_lanes))
        rsp_data[cap_idx*S +: S] <= mem_rdata;

      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            base      <= req_addr;
            n_lanes   <= req_is_vector ? IDX_W'(LANES) : IDX_W'(1);
            rsp_data  <= '0;
            rsp_oob   <= !next_in_range;
            req_ready <= 1'b0;
            issue_idx <= '0;
            mem_re    <= next_in_range;
            mem_addr  <= next_in_range ? next_addr[S-1:0] : '0;
            state     <= READ;
          end
        end
        READ: begin
          if (last_issued) begin
            mem_re   <= 1'b0;
            mem_addr <= '0;
            state    <= DRAIN;
          end else begin
            issue_idx <= next_idx;
            mem_re    <= next_in_range;
            mem_addr  <= next_in_range ? next_addr[S-1:0] : '0;
            if (!next_in_range)
              rsp_oob <= 1'b1;
          end
        end
        DRAIN: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_vector_reader.sv
// Directed bench for dmem_vector_reader with a behavioural one-cycle-latency RAM model.
module tb_dmem_vector_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_is_vector;
  logic         mem_re;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_rdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [191:0] rsp_data;
  logic         rsp_oob;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] ram [int unsigned];

  dmem_vector_reader dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_is_vector(req_is_vector),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_oob(rsp_oob)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 32'hC000_0000 | a;
  endfunction

  // Unread cycles return a marker so a capture without mem_re is visible in rsp_data.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram_word(mem_addr);
    else        mem_rdata <= 32'h5A5A_5A5A;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] a, input logic vec,
                                input logic rr);
    req_valid     = v;
    req_addr      = a;
    req_is_vector = vec;
    rsp_ready     = rr;
  endtask

  task automatic check_output(input string tag, input logic [191:0] observed,
                              input logic [191:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " req_ready"}, 192'(req_ready), 192'd1);
    check_output({tag, " mem_re"},    192'(mem_re),    192'd0);
    check_output({tag, " mem_addr"},  192'(mem_addr),  192'd0);
    check_output({tag, " rsp_valid"}, 192'(rsp_valid), 192'd0);
    check_output({tag, " rsp_data"},  rsp_data,        192'd0);
    check_output({tag, " rsp_oob"},   192'(rsp_oob),   192'd0);
  endtask

  localparam logic [191:0] EXP_T1 =
    192'h000000A5_000000A4_000000A3_000000A2_000000A1_000000A0;
  localparam logic [191:0] EXP_T2 = 192'hDEADBEEF;
  localparam logic [191:0] EXP_T3 =
    192'h00000000_00000000_00000000_C000753E_C000753D_C000753C;
  localparam logic [191:0] EXP_T5 = 192'h12345678;

  initial begin
    for (int i = 0; i < 6; i++) ram[100 + i] = 32'hA0 + i;
    ram[7]   = 32'hDEAD_BEEF;
    ram[300] = 32'h1234_5678;
    mem_rdata = '0;
    rst = 1'b1;
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // Vector read at 100, request inputs scrambled after accept
    apply_stimulus(1'b1, 32'd100, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0, 32'd9000 + 32'(i), 1'(i % 2), 1'b0);
      check_output($sformatf("t1 mem_re c%0d", i + 1), 192'(mem_re), 192'd1);
      check_output($sformatf("t1 mem_addr c%0d", i + 1), 192'(mem_addr), 192'(100 + i));
      check_output($sformatf("t1 req_ready c%0d", i + 1), 192'(req_ready), 192'd0);
      tick();
    end
    check_output("t1 drain mem_re", 192'(mem_re), 192'd0);
    check_output("t1 drain rsp_valid", 192'(rsp_valid), 192'd0);
    tick();
    check_output("t1 rsp_valid c8", 192'(rsp_valid), 192'd1);
    check_output("t1 rsp_data", rsp_data, EXP_T1);
    check_output("t1 rsp_oob", 192'(rsp_oob), 192'd0);
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1);
    tick();
    check_output("t1 post rsp_valid", 192'(rsp_valid), 192'd0);
    check_output("t1 post req_ready", 192'(req_ready), 192'd1);
    check_output("t1 post rsp_data held", rsp_data, EXP_T1);

    // Scalar read at 7; is_vector raised after accept must not add lanes
    apply_stimulus(1'b1, 32'd7, 1'b0, 1'b0);
    tick();
    check_output("t2 mem_re c1", 192'(mem_re), 192'd1);
    check_output("t2 mem_addr c1", 192'(mem_addr), 192'd7);
    check_output("t2 rsp_data cleared", rsp_data, 192'd0);
    apply_stimulus(1'b0, 32'd8, 1'b1, 1'b0);
    tick();
    check_output("t2 mem_re c2", 192'(mem_re), 192'd0);
    check_output("t2 rsp_valid c2", 192'(rsp_valid), 192'd0);
    tick();
    check_output("t2 rsp_valid c3", 192'(rsp_valid), 192'd1);
    check_output("t2 rsp_data", rsp_data, EXP_T2);
    check_output("t2 rsp_oob", 192'(rsp_oob), 192'd0);
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1);
    tick();
    check_output("t2 post req_ready", 192'(req_ready), 192'd1);

    // Vector read straddling the end of RAM, then a long stall in RESP
    apply_stimulus(1'b1, 32'd30012, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0);
      check_output($sformatf("t3 mem_re c%0d", i + 1), 192'(mem_re), (i < 3) ? 192'd1 : 192'd0);
      check_output($sformatf("t3 mem_addr c%0d", i + 1), 192'(mem_addr),
                   (i < 3) ? 192'(30012 + i) : 192'd0);
      tick();
    end
    tick();
    check_output("t3 rsp_valid c8", 192'(rsp_valid), 192'd1);
    check_output("t3 rsp_data", rsp_data, EXP_T3);
    check_output("t3 rsp_oob", 192'(rsp_oob), 192'd1);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 32'd50, 1'b1, 1'b0);
      check_output($sformatf("t4 stall rsp_valid %0d", i), 192'(rsp_valid), 192'd1);
      check_output($sformatf("t4 stall rsp_data %0d", i), rsp_data, EXP_T3);
      check_output($sformatf("t4 stall rsp_oob %0d", i), 192'(rsp_oob), 192'd1);
      check_output($sformatf("t4 stall req_ready %0d", i), 192'(req_ready), 192'd0);
      check_output($sformatf("t4 stall mem_re %0d", i), 192'(mem_re), 192'd0);
      tick();
    end
    apply_stimulus(1'b1, 32'd50, 1'b1, 1'b1);
    tick();
    check_output("t4 release rsp_valid", 192'(rsp_valid), 192'd0);
    check_output("t4 release req_ready", 192'(req_ready), 192'd1);
    check_output("t4 release mem_re", 192'(mem_re), 192'd0);
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    check_output("t4 no accept mem_re", 192'(mem_re), 192'd0);
    check_output("t4 idle req_ready", 192'(req_ready), 192'd1);

    // Asynchronous reset in cycle 4 of a vector read, then a clean scalar read
    apply_stimulus(1'b1, 32'd200, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("t5 async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check_reset_values("t5 released");
    apply_stimulus(1'b1, 32'd300, 1'b0, 1'b0);
    tick();
    check_output("t5 mem_addr c1", 192'(mem_addr), 192'd300);
    apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    tick();
    check_output("t5 rsp_valid c3", 192'(rsp_valid), 192'd1);
    check_output("t5 rsp_data", rsp_data, EXP_T5);
    check_output("t5 rsp_oob", 192'(rsp_oob), 192'd0);
    apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1);
    tick();
    check_output("t5 post req_ready", 192'(req_ready), 192'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
